fifo_led_sequencer: RTL and testbench
=====================================

// Module: fifo_led_sequencer
// PURPOSE
//  Downstream consumer for the button-driven 2^W x B FIFO on the Mark1 board.
//  - Pops words from the FIFO read port one at a time.
//  - Holds each word on the LEDs for a fixed dwell time.
//  - Replaces the manual debounced read button with a paced, automatic drain.
//  - Interfaces to a first-word-fall-through FIFO: r_data is valid while empty=0; rd is a 1-cycle pop.
// PARAMETERS
//  B            3           data width; must match the FIFO B
//  HOLD_CYCLES  50_000_000  dwell per word in clk cycles (1 s @ 50 MHz); legal range >= 2
//  GAP_CYCLES   5_000_000   blank gap between words (used only with FIFO_SEQ_GAP_EN); legal range >= 1
//  CNT_W        8           width of shown_count
// PORTS
//  clk          in   1      system clock; all state on rising edge
//  reset        in   1      asynchronous, active-low reset
//  en           in   1      level; 1 = drain enabled, 0 = pause after current dwell
//  empty        in   1      FIFO empty flag
//  r_data       in   B      FIFO head word (valid when empty=0)
//  rd           out  1      FIFO pop strobe, exactly 1 cycle per consumed word
//  led_data     out  B      word currently displayed
//  led_valid    out  1      1 while a word is in its dwell
//  busy         out  1      1 in any state other than IDLE
//  shown_count  out  CNT_W  number of words consumed since reset; wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; rd=0, led_data=0, led_valid=0, busy=0, shown_count=0, dwell counter=0.
//  Dwell counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1); loads are truncation-free by construction.
//  States: IDLE, HOLD (plus GAP when the macro is defined).
//  IDLE:  if en=1 && empty=0, then in that same cycle:
//         - rd=1 (combinational from state/inputs);
//         - next edge: led_data<=r_data, led_valid<=1, counter<=HOLD_CYCLES-1, shown_count+=1, state<=HOLD.
//         Otherwise remain in IDLE with led_valid=0; led_data keeps its last value.
//  HOLD:  counter decrements each cycle; rd=0. At counter==0:
//         - no gap: if en=1 && empty=0, assert rd and reload exactly as from IDLE (back-to-back; the
//           dwell is exactly HOLD_CYCLES cycles per word); else state<=IDLE, led_valid<=0.
//  Latency: the word appears on led_data/led_valid 1 cycle after the rd pulse.
//  rd is never asserted while empty=1; at most one rd per word; no rd in HOLD before counter==0.
//  en falling mid-HOLD: the current dwell completes, then the block goes to IDLE; no further pop.
//  empty rising mid-HOLD: no effect until counter==0.
//  A FIFO write in the same cycle as rd is the FIFO's concern; this block only reads empty/r_data.
//  Reset mid-HOLD: immediate return to reset values. A word already popped is lost (by design).
//  busy = (state != IDLE).
// CONFIGURATION
//  FIFO_SEQ_GAP_EN defined:
//   - At HOLD counter==0: state<=GAP, led_valid<=0, led_data<=0, counter<=GAP_CYCLES-1.
//   - In GAP: decrement the counter. At 0: if en=1 && empty=0, pop and enter HOLD; else go to IDLE.
//   - Period per word = HOLD_CYCLES + GAP_CYCLES, so repeated equal words are visibly separated.
//  FIFO_SEQ_GAP_EN undefined:
//   - No GAP state exists and GAP_CYCLES is unused; behaviour is exactly as in BEHAVIOUR.
// TESTING (bench: HOLD_CYCLES=4, GAP_CYCLES=2, B=3, CNT_W=8; FIFO model is FWFT depth 4)
//  1 Reset: reset=0 at any time -> all outputs 0 on the next sample; release with FIFO empty
//    -> stays in IDLE, rd never asserted.
//  2 Write 3'b101, en=1 -> rd high for 1 cycle; next cycle led_data=101, led_valid=1, shown_count=1;
//    led_valid high exactly 4 cycles, then 0.
//  3 Preload 3,5,7, en=1 (no gap) -> exactly 3 rd pulses 4 cycles apart; led_data 3,5,7 contiguous;
//    final shown_count=3, then empty and IDLE.
//  4 Same stimulus with FIFO_SEQ_GAP_EN -> rd pulses 6 cycles apart; led_data=0 and led_valid=0
//    for 2 cycles between words.
//  5 Drop en=0 two cycles into the dwell of word 1 of 2 -> dwell completes, no second rd;
//    re-assert en -> word 2 is popped the next cycle.
//  6 Assert reset mid-HOLD -> outputs 0 asynchronously; after release with FIFO non-empty and en=1
//    -> a new pop occurs; shown_count restarts at 1.
//  Wrap: force 256 pops -> shown_count returns to 0.
//  Assertion (all runs): rd && empty never true.

Source files
------------

// File: rtl/fifo_led_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_led_sequencer_if
//  Description : Read-port bundle of a first-word-fall-through FIFO.
//                master = consumer issuing the pop strobe,
//                slave  = FIFO presenting the head word and empty flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_led_sequencer_if #(
    parameter int B = 3
);
    logic         empty;
    logic [B-1:0] r_data;
    logic         rd;

    modport master (
        output rd,
        input  empty,
        input  r_data
    );

    modport slave (
        input  rd,
        output empty,
        output r_data
    );
endinterface
`default_nettype wire

// File: rtl/fifo_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_led_sequencer
//  Description : Paced automatic drain of a FWFT FIFO onto the board LEDs.
//                Each word is popped with a single-cycle rd strobe and held on
//                led_data for HOLD_CYCLES clocks.
//                Optional macro FIFO_SEQ_GAP_EN inserts a blanked gap of
//                GAP_CYCLES clocks between consecutive words.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_led_sequencer #(
    parameter int B           = 3,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 5_000_000,
    parameter int CNT_W       = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             en,
    fifo_led_sequencer_if.master  fifo,
    output logic [B-1:0]          led_data,
    output logic                  led_valid,
    output logic                  busy,
    output logic [CNT_W-1:0]      shown_count
);

    // Dwell counter is sized for the larger of the two loads, so loads never truncate.
    localparam int C_CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int C_DW      = $clog2(C_CNT_MAX + 1);

    localparam logic [C_DW-1:0] C_HOLD_LOAD = C_DW'(HOLD_CYCLES - 1);
`ifdef FIFO_SEQ_GAP_EN
    localparam logic [C_DW-1:0] C_GAP_LOAD  = C_DW'(GAP_CYCLES - 1);
`endif

`ifdef FIFO_SEQ_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_n;
    logic [C_DW-1:0]   r_cnt;
    logic [C_DW-1:0]   w_cnt_n;
    logic [B-1:0]      r_led_data;
    logic [B-1:0]      w_led_data_n;
    logic              r_led_valid;
    logic              w_led_valid_n;
    logic [CNT_W-1:0]  r_shown;
    logic [CNT_W-1:0]  w_shown_n;
    logic              w_can_pop;
    logic              w_pop;

    assign w_can_pop = en && !fifo.empty;

    // State and datapath registers; reset wins immediately, dropping any word on display.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_led_data  <= '0;
            r_led_valid <= 1'b0;
            r_shown     <= '0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_led_data  <= w_led_data_n;
            r_led_valid <= w_led_valid_n;
            r_shown     <= w_shown_n;
        end
    end

    // Next-state logic: count down the dwell/gap, and pop whenever a period ends with data ready.
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_led_data_n  = r_led_data;
        w_led_valid_n = r_led_valid;
        w_shown_n     = r_shown;
        w_pop         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_led_valid_n = 1'b0;
                if (w_can_pop) begin
                    w_pop = 1'b1;
                end
            end

            ST_HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - C_DW'(1);
                end else begin
`ifdef FIFO_SEQ_GAP_EN
                    // Blank the LEDs so repeated equal words are visibly separated.
                    w_state_n     = ST_GAP;
                    w_led_valid_n = 1'b0;
                    w_led_data_n  = '0;
                    w_cnt_n       = C_GAP_LOAD;
`else
                    if (w_can_pop) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_n     = ST_IDLE;
                        w_led_valid_n = 1'b0;
                    end
`endif
                end
            end

`ifdef FIFO_SEQ_GAP_EN
            ST_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - C_DW'(1);
                end else if (w_can_pop) begin
                    w_pop = 1'b1;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
`endif

            default: begin
                w_state_n     = ST_IDLE;
                w_led_valid_n = 1'b0;
            end
        endcase

        // A pop latches the FWFT head word and starts a fresh dwell.
        if (w_pop) begin
            w_state_n     = ST_HOLD;
            w_led_data_n  = fifo.r_data;
            w_led_valid_n = 1'b1;
            w_cnt_n       = C_HOLD_LOAD;
            w_shown_n     = r_shown + CNT_W'(1);
        end
    end

    // Pop strobe is suppressed while reset is held so nothing is consumed during reset.
    assign fifo.rd     = w_pop && reset;
    assign led_data    = r_led_data;
    assign led_valid   = r_led_valid;
    assign busy        = (r_state != ST_IDLE);
    assign shown_count = r_shown;

endmodule
`default_nettype wire

// File: tb/tb_fifo_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_led_sequencer
//  Description : Self-checking bench for fifo_led_sequencer with a depth-4
//                FWFT FIFO model and a timeline reference model.
//                Honours FIFO_SEQ_GAP_EN in the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_led_sequencer;

    localparam int B     = 3;
    localparam int HOLD  = 4;
    localparam int GAP   = 2;
    localparam int CNT_W = 8;
`ifdef FIFO_SEQ_GAP_EN
    localparam int P = HOLD + GAP;
`else
    localparam int P = HOLD;
`endif

    logic             clk;
    logic             reset;
    logic             en;
    logic [B-1:0]     led_data;
    logic             led_valid;
    logic             busy;
    logic [CNT_W-1:0] shown_count;

    fifo_led_sequencer_if #(.B(B)) fif ();

    fifo_led_sequencer #(
        .B          (B),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .fifo       (fif.master),
        .led_data   (led_data),
        .led_valid  (led_valid),
        .busy       (busy),
        .shown_count(shown_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // FIFO contents (environment) and timeline model state
    logic [B-1:0] q[$];
    int           cyc       = 0;
    int           last_pop  = 0;
    bit           has_pop   = 0;
    int           pops      = 0;
    logic [B-1:0] last_word = '0;

    // rd must never coincide with empty
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if (fif.rd && fif.empty) begin
                failures++;
                $display("FAIL rd_while_empty t=%0t rd=%b empty=%b required rd=0", $time, fif.rd, fif.empty);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic refresh();
        fif.empty  = (q.size() == 0);
        fif.r_data = (q.size() == 0) ? '0 : q[0];
    endtask

    task automatic push(input logic [B-1:0] w);
        if (q.size() < 4) q.push_back(w);
        refresh();
    endtask

    task automatic model_reset();
        has_pop   = 0;
        pops      = 0;
        last_word = '0;
    endtask

    // Expected {rd, led_valid, busy, led_data, shown_count} for the current cycle.
    // A word is popped at cycle t0, displayed on t0+1..t0+HOLD, and the next pop
    // is permitted from t0+P onward.
    function automatic logic [13:0] m_out();
        int           d;
        bit           r, v, b;
        logic [B-1:0] dat;
        r = reset && en && !fif.empty && (!has_pop || cyc >= last_pop + P);
        d = cyc - last_pop;
        v = has_pop && d >= 1 && d <= HOLD;
        b = has_pop && d >= 1 && d <= P;
`ifdef FIFO_SEQ_GAP_EN
        dat = v ? last_word : '0;
`else
        dat = last_word;
`endif
        return {r, v, b, dat, pops[7:0]};
    endfunction

    // Advance one clock: FIFO reacts to the DUT strobe, model to its own prediction.
    task automatic tick(input bit mrd);
        logic [B-1:0] head;
        bit           drd;
        drd  = fif.rd;
        head = (q.size() > 0) ? q[0] : '0;
        @(posedge clk);
        if (mrd) begin
            has_pop   = 1;
            last_pop  = cyc;
            last_word = head;
            pops++;
        end
        if (drd && q.size() > 0) void'(q.pop_front());
        cyc++;
        #1 refresh();
    endtask

    task automatic test_reset();
        logic [13:0] e;
        reset = 1'b0;
        en    = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({fif.rd, led_valid, busy, led_data, shown_count} !== 14'd0) begin
            failures++;
            $display("FAIL reset_values got=%h required=0", {fif.rd, led_valid, busy, led_data, shown_count});
        end
        en    = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = m_out();
            checks++;
            if ({fif.rd, led_valid, busy, led_data, shown_count} !== e) begin
                failures++;
                $display("FAIL reset_idle i=%0d got=%h required=%h", i, {fif.rd, led_valid, busy, led_data, shown_count}, e);
            end
            tick(e[13]);
        end
    endtask

    task automatic test_single();
        logic [13:0] e;
        int vcnt = 0;
        int rcnt = 0;
        push(3'b101);
        for (int i = 0; i < P + 4; i++) begin
            @(negedge clk);
            e = m_out();
            vcnt += led_valid;
            rcnt += fif.rd;
            checks++;
            if ({fif.rd, led_valid, busy, led_data, shown_count} !== e) begin
                failures++;
                $display("FAIL single i=%0d got=%h required=%h", i, {fif.rd, led_valid, busy, led_data, shown_count}, e);
            end
            tick(e[13]);
        end
        checks++;
        if (vcnt != HOLD || rcnt != 1) begin
            failures++;
            $display("FAIL single_dwell valid_cycles=%0d rd_pulses=%0d required %0d and 1", vcnt, rcnt, HOLD);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] e;
        int rd_at[$];
        push(3'd3);
        push(3'd5);
        push(3'd7);
        for (int i = 0; i < 3 * P + 4; i++) begin
            @(negedge clk);
            e = m_out();
            if (fif.rd) rd_at.push_back(i);
            checks++;
            if ({fif.rd, led_valid, busy, led_data, shown_count} !== e) begin
                failures++;
                $display("FAIL back_to_back i=%0d got=%h required=%h", i, {fif.rd, led_valid, busy, led_data, shown_count}, e);
            end
            tick(e[13]);
        end
        checks++;
        if (rd_at.size() != 3) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d required=3", rd_at.size());
        end else if (rd_at[1] - rd_at[0] != P || rd_at[2] - rd_at[1] != P) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d,%0d required=%0d", rd_at[1] - rd_at[0], rd_at[2] - rd_at[1], P);
        end
        checks++;
        if (busy !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL b2b_drained busy=%b fifo_level=%0d required 0 and 0", busy, q.size());
        end
    endtask

    task automatic test_en_pause();
        logic [13:0] e;
        int rd_at[$];
        push(3'($urandom));
        push(3'($urandom));
        for (int i = 0; i < 20; i++) begin
            if (i == 2)  en = 1'b0;
            if (i == 12) en = 1'b1;
            @(negedge clk);
            e = m_out();
            if (fif.rd) rd_at.push_back(i);
            checks++;
            if ({fif.rd, led_valid, busy, led_data, shown_count} !== e) begin
                failures++;
                $display("FAIL en_pause i=%0d got=%h required=%h", i, {fif.rd, led_valid, busy, led_data, shown_count}, e);
            end
            tick(e[13]);
        end
        checks++;
        if (rd_at.size() != 2 || rd_at[0] != 0 || rd_at[1] != 12) begin
            failures++;
            $display("FAIL en_pause_pops count=%0d required pops at cycles 0 and 12", rd_at.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] e;
        push(3'($urandom));
        push(3'($urandom));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = m_out();
            checks++;
            if ({fif.rd, led_valid, busy, led_data, shown_count} !== e) begin
                failures++;
                $display("FAIL reset_mid_pre i=%0d got=%h required=%h", i, {fif.rd, led_valid, busy, led_data, shown_count}, e);
            end
            tick(e[13]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({fif.rd, led_valid, busy, led_data, shown_count} !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid_async got=%h required=0", {fif.rd, led_valid, busy, led_data, shown_count});
        end
        model_reset();
        @(posedge clk);
        cyc++;
        #1 reset = 1'b1;
        refresh();
        for (int i = 0; i < P + 3; i++) begin
            @(negedge clk);
            e = m_out();
            checks++;
            if ({fif.rd, led_valid, busy, led_data, shown_count} !== e) begin
                failures++;
                $display("FAIL reset_mid_post i=%0d got=%h required=%h", i, {fif.rd, led_valid, busy, led_data, shown_count}, e);
            end
            tick(e[13]);
        end
        checks++;
        if (shown_count !== 8'd1) begin
            failures++;
            $display("FAIL reset_mid_count got=%0d required=1", shown_count);
        end
    endtask

    task automatic test_random();
        logic [13:0] e;
        for (int i = 0; i < 400; i++) begin
            if (i < 320) begin
                en = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 9) < 3) push(3'($urandom));
            end else begin
                en = 1'b1;
            end
            @(negedge clk);
            e = m_out();
            checks++;
            if ({fif.rd, led_valid, busy, led_data, shown_count} !== e) begin
                failures++;
                $display("FAIL random i=%0d got=%h required=%h", i, {fif.rd, led_valid, busy, led_data, shown_count}, e);
            end
            tick(e[13]);
        end
    endtask

    task automatic test_wrap();
        logic [13:0] e;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        cyc++;
        #1 reset = 1'b1;
        en = 1'b1;
        refresh();
        for (int i = 0; i < 300 * P && pops < 256; i++) begin
            while (q.size() < 4) push(3'($urandom));
            @(negedge clk);
            e = m_out();
            checks++;
            if ({fif.rd, led_valid, busy, led_data, shown_count} !== e) begin
                failures++;
                $display("FAIL wrap i=%0d got=%h required=%h", i, {fif.rd, led_valid, busy, led_data, shown_count}, e);
            end
            tick(e[13]);
        end
        checks++;
        if (pops != 256) begin
            failures++;
            $display("FAIL wrap_timeout pops=%0d required=256", pops);
        end
        @(negedge clk);
        checks++;
        if (shown_count !== 8'd0) begin
            failures++;
            $display("FAIL wrap_count got=%0d required=0", shown_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_en_pause();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
